aud_wave_gen: RTL and testbench

Phase-to-sample shaper that sits directly downstream of `aud_counter` in the synth voice path. On each phase strobe it captures the counter's `value` and `max` and normalises the phase to an 8-bit ramp with a serial restoring divider. It then shapes the ramp into a saw, square, triangle or silence sample. Samples are presented with a one-cycle valid pulse to the mixer/DAC stage at a fixed latency.

---
 rtl/aud_pkg.sv | 24 ++
 rtl/aud_frac_div.sv | 68 ++++++
 rtl/aud_wave_gen.sv | 88 ++++++++
 tb/tb_aud_wave_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio waveform path.
// Waveform selects, shaper FSM states and midscale helper.
package aud_pkg;

  typedef enum logic [1:0] {
    SAW     = 2'd0,
    SQUARE  = 2'd1,
    TRI     = 2'd2,
    SILENCE = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic [31:0] midscale(
    input int w
  );
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/aud_frac_div.sv
// W-step serial restoring divider: quo = floor(num * 2^W / den).
// Degenerate inputs are flagged at start; step count stays fixed.
module aud_frac_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [W-1:0] quo,
  output logic         done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W:0]    rem;
  logic [W:0]    shifted;
  logic [W:0]    den_x;
  logic          ge;
  logic [W-1:0]  q;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt;
  logic          running;
  logic          force_zero;
  logic          force_ones;

  assign den_x   = {1'b0, den_q};
  assign shifted = rem << 1;
  assign ge      = shifted >= den_x;
  assign done    = running && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem        <= '0;
      q          <= '0;
      den_q      <= '0;
      cnt        <= '0;
      running    <= 1'b0;
      force_zero <= 1'b0;
      force_ones <= 1'b0;
    end else if (start) begin
      rem        <= {1'b0, num};
      q          <= '0;
      den_q      <= den;
      cnt        <= '0;
      running    <= 1'b1;
      force_zero <= den <= W'(1);
      force_ones <= num >= den;
    end else if (running) begin
      rem     <= ge ? shifted - den_x : shifted;
      q       <= {q[W-2:0], ge};
      cnt     <= cnt + 1'b1;
      running <= !done;
    end
  end

  // max <= 1 wins over phase >= max
  always_comb begin
    quo = q;
    if (force_zero)
      quo = '0;
    else if (force_ones)
      quo = '1;
  end

endmodule

// File: rtl/aud_wave_gen.sv
// Phase-to-sample shaper: normalises counter phase to a ramp,
// then shapes it into saw/square/triangle/silence samples.
module aud_wave_gen
  import aud_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         phase_strobe,
  input  logic [W-1:0] phase,
  input  logic [W-1:0] max,
  input  logic [1:0]   wave_sel,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         busy,
  output logic         overrun
);

  localparam logic [W-1:0] MID = W'(midscale(W));

  state_t       state;
  state_t       state_nxt;
  wave_t        sel_q;
  logic [W-1:0] ramp;
  logic [W-1:0] shaped;
  logic         div_done;
  logic         capture;
  logic         msb;

  assign busy    = state != IDLE;
  assign capture = phase_strobe && !busy;
  assign msb     = ramp[W-1];

  aud_frac_div #(
    .W(W)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .start(capture),
    .num  (phase),
    .den  (max),
    .quo  (ramp),
    .done (div_done)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (phase_strobe) state_nxt = DIV;
      DIV:     if (div_done) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shaped = MID;
    unique case (sel_q)
      SAW:     shaped = ramp;
      SQUARE:  shaped = msb ? '0 : '1;
      TRI:     shaped = (msb ? ~ramp : ramp) << 1;
      SILENCE: shaped = MID;
      default: shaped = MID;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sel_q        <= SILENCE;
      sample       <= MID;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sample_valid <= state == OUT;
      if (state == OUT)
        sample <= shaped;
      // new waveform only at a period wrap
      if (capture && phase == '0)
        sel_q <= wave_t'(wave_sel);
      if (phase_strobe && busy)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aud_wave_gen.sv
// Randomised self-checking bench for aud_wave_gen (W = 8)
// against an arithmetic reference model.
module tb_aud_wave_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       phase_strobe = 1'b0;
  logic [7:0] phase = '0;
  logic [7:0] mx = '0;
  logic [1:0] wave_sel = '0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int msel = 3;
  int prev_s = 128;

  always #5 clk = ~clk;

  aud_wave_gen #(
    .W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_strobe(phase_strobe),
    .phase       (phase),
    .max         (mx),
    .wave_sel    (wave_sel),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(
    input int ph,
    input int m,
    input int sel
  );
    int r;
    if (m <= 1) r = 0;
    else if (ph >= m) r = 255;
    else r = (ph * 256) / m;
    case (sel)
      0: return r;
      1: return (r < 128) ? 255 : 0;
      2: return (r < 128) ? (2 * r) % 256 : (2 * (255 - r)) % 256;
      default: return 128;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(
    input int lat0,
    input int exp
  );
    int lat = lat0;
    while (!sample_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 10);
    check("sample", sample, exp);
    check("busy_at_valid", busy, 0);
    prev_s = exp;
  endtask

  task automatic xact(
    input int ph,
    input int m,
    input int sel,
    input bit b2b
  );
    int exp;
    if (!b2b) tick();
    phase_strobe = 1'b1;
    phase = 8'(ph);
    mx = 8'(m);
    wave_sel = 2'(sel);
    if (ph == 0) msel = sel;
    exp = model(ph, m, msel);
    tick();
    phase_strobe = 1'b0;
    check("valid_low_n1", sample_valid, 0);
    check("busy_n1", busy, 1);
    check("sample_hold", sample, prev_s);
    wait_valid(1, exp);
  endtask

  initial begin
    int exp;
    int seen;
    repeat (3) tick();
    check("rst_sample", sample, 128);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;
    tick();

    xact(0, 100, 0, 0);
    xact(50, 100, 1, 0);
    xact(25, 100, 2, 1);
    xact(2, 3, 3, 0);
    xact(0, 100, 2, 0);
    xact(50, 100, 0, 0);
    xact(25, 100, 0, 1);
    xact(0, 100, 1, 0);
    xact(25, 100, 0, 0);
    xact(50, 100, 0, 0);
    xact(0, 100, 0, 0);
    xact(30, 100, 1, 0);
    xact(40, 100, 1, 1);
    xact(0, 100, 1, 0);
    xact(25, 100, 1, 0);
    xact(0, 100, 0, 0);
    xact(5, 0, 1, 0);
    xact(0, 1, 0, 0);
    xact(120, 100, 2, 0);
    check("overrun_clean", overrun, 0);

    tick();
    phase_strobe = 1'b1;
    phase = 8'd50;
    mx = 8'd100;
    wave_sel = 2'd0;
    exp = model(50, 100, msel);
    tick();
    phase_strobe = 1'b0;
    repeat (4) tick();
    phase_strobe = 1'b1;
    phase = 8'd0;
    wave_sel = 2'd2;
    tick();
    phase_strobe = 1'b0;
    check("overrun_set", overrun, 1);
    wait_valid(6, exp);
    xact(25, 100, 2, 0);
    check("overrun_sticky", overrun, 1);

    for (int i = 0; i < 40; i++) begin
      int ph;
      ph = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      xact(ph, $urandom_range(0, 255), $urandom_range(0, 3),
           1'($urandom_range(0, 1)));
    end

    tick();
    phase_strobe = 1'b1;
    phase = 8'd0;
    mx = 8'd100;
    wave_sel = 2'd0;
    tick();
    phase_strobe = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_sample", sample, 128);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    msel = 3;
    prev_s = 128;
    repeat (2) tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sample_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    xact(40, 100, 1, 0);
    xact(0, 100, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
